// File: rtl/fsk_mod_pkg.sv
// Shared types and constants for the binary FSK modulator.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state encoding, default tuning words and LUT geometry, and the
// elaboration-time quarter-sine generator used to fill the ROM.
package fsk_mod_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int          LUT_AW_DEF  = 10;
    localparam logic [31:0] F0_WORD_DEF = 32'h1000_0000;
    localparam logic [31:0] F1_WORD_DEF = 32'h2000_0000;
    localparam int          PEAK_MAG    = 16383;

    localparam real PI_R = 3.14159265358979323846;

    // round(peak * sin(pi/2 * idx/depth)). Evaluated only at elaboration to
    // build the ROM contents. A 10-term Taylor series stays far below one
    // LSB of error over [0, pi/2].
    function automatic int quarter_sine_q(input int idx, input int depth, input int peak);
        real x;
        real term;
        real acc;
        x    = PI_R * real'(idx) / (2.0 * real'(depth));
        term = x;
        acc  = x;
        for (int k = 1; k <= 10; k++) begin
            term = -term * x * x / real'((2 * k) * (2 * k + 1));
            acc  = acc + term;
        end
        return $rtoi(real'(peak) * acc + 0.5);
    endfunction

endpackage

// File: rtl/fsk_mod_sin_lut.sv
// Quarter-wave sine ROM, one entry per address, registered read.
// Latency: 1 clock from addr_i to dat_o.
// Backpressure: none; reads every clock.
// Ports: clk, addr_i (quarter-wave index), dat_o (unsigned magnitude).
module fsk_mod_sin_lut
    import fsk_mod_pkg::*;
#(
    parameter int AW    = LUT_AW_DEF,
    parameter int MAG_W = 14
) (
    input  logic             clk,
    input  logic [AW-1:0]    addr_i,
    output logic [MAG_W-1:0] dat_o
);

    localparam int DEPTH = 1 << AW;

    typedef logic [MAG_W-1:0] rom_t [DEPTH];

    function automatic rom_t build_rom();
        rom_t r;
        for (int i = 0; i < DEPTH; i++) begin
            r[i] = MAG_W'(quarter_sine_q(i, DEPTH, (1 << MAG_W) - 1));
        end
        return r;
    endfunction

    localparam rom_t ROM = build_rom();

    // No reset on the read register so the array maps onto block RAM; the
    // consumer gates the data with its own reset-cleared valid.
    logic [MAG_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        rdata_q <= ROM[addr_i];
    end

    assign dat_o = rdata_q;

endmodule

// File: rtl/fsk_mod.sv
// Binary FSK modulator: one bit per SYM_LEN clocks, phase-continuous sine at F0/F1.
// Latency: dout/dout_valid/sym_strobe lag the phase/symbol-counter cycle by 2 clocks.
// Backpressure: din_ready only in IDLE or on the last cycle of a symbol; gaps end the burst.
// Ports: clk, rst (async, active high), din/din_valid/din_ready (bit handshake),
//        dout (signed sample), dout_valid, sym_strobe (sample 0 of each symbol), busy (in RUN).
module fsk_mod
    import fsk_mod_pkg::*;
#(
    parameter int                 PHASE_W = 32,
    parameter int                 LUT_AW  = LUT_AW_DEF,
    parameter int                 OUT_W   = 15,
    parameter int                 SYM_LEN = 32,
    parameter logic [PHASE_W-1:0] F0_WORD = F0_WORD_DEF,
    parameter logic [PHASE_W-1:0] F1_WORD = F1_WORD_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    din,
    input  logic                    din_valid,
    output logic                    din_ready,
    output logic signed [OUT_W-1:0] dout,
    output logic                    dout_valid,
    output logic                    sym_strobe,
    output logic                    busy
);

    localparam int               MAG_W = OUT_W - 1;
    localparam int               CNT_W = (SYM_LEN > 2) ? $clog2(SYM_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(SYM_LEN - 1);
    localparam logic [MAG_W-1:0] PEAK  = {MAG_W{1'b1}};

    // ---------------- FSM, symbol counter, NCO ----------------
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     sym_cnt_q, sym_cnt_d;
    logic [PHASE_W-1:0]   phase_q, phase_d;
    logic [PHASE_W-1:0]   fcw_q, fcw_d;
    logic                 xfer;
    logic                 last_cyc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            sym_cnt_q <= '0;
            phase_q   <= '0;
            fcw_q     <= '0;
        end else begin
            state_q   <= state_d;
            sym_cnt_q <= sym_cnt_d;
            phase_q   <= phase_d;
            fcw_q     <= fcw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sym_cnt_d = sym_cnt_q;
        phase_d   = phase_q;
        fcw_d     = fcw_q;

        last_cyc  = (state_q == ST_RUN) && (sym_cnt_q == LAST);
        din_ready = (state_q == ST_IDLE) || last_cyc;
        xfer      = din_valid && din_ready;

        // The boundary cycle still advances by the outgoing fcw, so the next
        // symbol starts exactly where the previous one left off.
        if (state_q == ST_RUN) begin
            phase_d = phase_q + fcw_q;
        end

        if (xfer) begin
            state_d   = ST_RUN;
            sym_cnt_d = '0;
            fcw_d     = din ? F1_WORD : F0_WORD;
        end else if (state_q == ST_RUN) begin
            if (last_cyc) begin
                state_d   = ST_IDLE;
                sym_cnt_d = '0;
            end else begin
                sym_cnt_d = sym_cnt_q + 1'b1;
            end
        end
    end

    assign busy = (state_q == ST_RUN);

    // ---------------- quadrant decode into the quarter-wave ROM ----------------
    logic [1:0]        quad;
    logic [LUT_AW-1:0] qaddr;
    logic [LUT_AW-1:0] lut_addr;
    logic [MAG_W-1:0]  lut_dat;

    assign quad  = phase_q[PHASE_W-1 -: 2];
    assign qaddr = phase_q[PHASE_W-3 -: LUT_AW];
    // Odd quadrants run the table backwards: index (DEPTH - a) mod DEPTH == -a.
    // a == 0 there would need entry DEPTH, which is the peak and is handled
    // by the peak flag instead.
    assign lut_addr = quad[0] ? (LUT_AW'(0) - qaddr) : qaddr;

    fsk_mod_sin_lut #(
        .AW    (LUT_AW),
        .MAG_W (MAG_W)
    ) u_lut (
        .clk    (clk),
        .addr_i (lut_addr),
        .dat_o  (lut_dat)
    );

    // ---------------- stage 1: flags alongside the registered ROM read ----------------
    logic s1_vld_q, s1_stb_q, s1_neg_q, s1_peak_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld_q  <= 1'b0;
            s1_stb_q  <= 1'b0;
            s1_neg_q  <= 1'b0;
            s1_peak_q <= 1'b0;
        end else begin
            s1_vld_q  <= busy;
            s1_stb_q  <= busy && (sym_cnt_q == '0);
            s1_neg_q  <= quad[1];
            s1_peak_q <= quad[0] && (qaddr == '0);
        end
    end

    // ---------------- stage 2: apply sign, zero when not valid ----------------
    logic [MAG_W-1:0]        mag;
    logic signed [OUT_W-1:0] mag_s;
    logic signed [OUT_W-1:0] dout_d, dout_q;
    logic                    vld_q, stb_q;

    always_comb begin
        mag    = s1_peak_q ? PEAK : lut_dat;
        mag_s  = signed'({1'b0, mag});
        dout_d = '0;
        if (s1_vld_q) begin
            dout_d = s1_neg_q ? -mag_s : mag_s;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout_q <= '0;
            vld_q  <= 1'b0;
            stb_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            vld_q  <= s1_vld_q;
            stb_q  <= s1_stb_q;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = vld_q;
    assign sym_strobe = stb_q;

endmodule
